// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes the IF/ID instruction, detects load-use
// hazards against the instruction already in ID/EX, and registers the result.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_id_inst,
  input  logic [31:0] if_id_pc,
  input  logic        if_id_valid,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  output logic [31:0] id_ex_inst,
  output logic [31:0] id_ex_pc,
  output logic [31:0] id_ex_rs_data,
  output logic [31:0] id_ex_rt_data,
  output logic [31:0] id_ex_imm,
  output logic [4:0]  id_ex_dest,
  output logic        id_ex_reg_write,
  output logic        id_ex_mem_read,
  output logic        id_ex_mem_write,
  output logic        id_ex_branch,
  output logic        id_ex_valid,
  output logic        id_ex_illegal,
  output logic        stall
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_ORI   = 6'b000001,
    OP_SUBI  = 6'b000110,
    OP_ADDUI = 6'b000111,
    OP_LH    = 6'b001000,
    OP_SB    = 6'b001001,
    OP_BNE   = 6'b001011
  } opcode_e;

  typedef enum logic [5:0] {
    FN_SLL  = 6'b000010,
    FN_XNOR = 6'b000100,
    FN_NAND = 6'b000101
  } funct_e;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs_idx, rt_idx, rd_idx;
  logic [31:0] imm_sext, imm_zext;

  logic        dec_legal, dec_use_rt, dec_rw, dec_mr, dec_mw, dec_br;
  logic [4:0]  dec_dest;
  logic [31:0] dec_imm;

  logic        hazard, load;

  logic [31:0] inst_q, inst_d, pc_q, pc_d, rs_q, rs_d, rt_q, rt_d, imm_q, imm_d;
  logic [4:0]  dest_q, dest_d;
  logic        rw_q, rw_d, mr_q, mr_d, mw_q, mw_d, br_q, br_d;
  logic        valid_q, valid_d, ill_q, ill_d;

  assign opcode   = if_id_inst[31:26];
  assign funct    = if_id_inst[5:0];
  assign rs_idx   = if_id_inst[25:21];
  assign rt_idx   = if_id_inst[20:16];
  assign rd_idx   = if_id_inst[15:11];
  assign imm_sext = {{16{if_id_inst[15]}}, if_id_inst[15:0]};
  assign imm_zext = {16'h0000, if_id_inst[15:0]};

  always_comb begin
    dec_legal  = 1'b0;
    dec_use_rt = 1'b0;
    dec_mr     = 1'b0;
    dec_mw     = 1'b0;
    dec_br     = 1'b0;
    dec_dest   = '0;
    dec_imm    = '0;
    case (opcode)
      OP_RTYPE: begin
        dec_legal  = (funct == FN_SLL) || (funct == FN_XNOR) || (funct == FN_NAND);
        dec_use_rt = dec_legal;
        dec_dest   = rd_idx;
      end
      OP_ORI, OP_ADDUI: begin
        dec_legal = 1'b1;
        dec_dest  = rt_idx;
        dec_imm   = imm_zext;
      end
      OP_SUBI: begin
        dec_legal = 1'b1;
        dec_dest  = rt_idx;
        dec_imm   = imm_sext;
      end
      OP_LH: begin
        dec_legal = 1'b1;
        dec_mr    = 1'b1;
        dec_dest  = rt_idx;
        dec_imm   = imm_sext;
      end
      OP_SB: begin
        dec_legal  = 1'b1;
        dec_use_rt = 1'b1;
        dec_mw     = 1'b1;
        dec_imm    = imm_sext;
      end
      OP_BNE: begin
        dec_legal  = 1'b1;
        dec_use_rt = 1'b1;
        dec_br     = 1'b1;
        dec_imm    = imm_sext;
      end
      default: ;
    endcase
    dec_rw = dec_legal && (dec_dest != 5'd0);
  end

  // Illegal instructions read no sources, so they can never trigger a stall.
  assign hazard = (dest_q != 5'd0) &&
                  ((dec_legal && (dest_q == rs_idx)) || (dec_use_rt && (dest_q == rt_idx)));
  assign stall  = !rst && valid_q && mr_q && hazard && if_id_valid && !flush;
  assign load   = if_id_valid && !flush && !stall && dec_legal;

  always_comb begin
    ill_d   = if_id_valid && !flush && !stall && !dec_legal;
    valid_d = load;
    inst_d  = load ? if_id_inst : '0;
    pc_d    = load ? if_id_pc   : '0;
    rs_d    = load ? rs_data    : '0;
    rt_d    = load ? rt_data    : '0;
    imm_d   = load ? dec_imm    : '0;
    dest_d  = load ? dec_dest   : '0;
    rw_d    = load && dec_rw;
    mr_d    = load && dec_mr;
    mw_d    = load && dec_mw;
    br_d    = load && dec_br;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_q  <= '0;
      pc_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      imm_q   <= '0;
      dest_q  <= '0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      br_q    <= 1'b0;
      valid_q <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      imm_q   <= imm_d;
      dest_q  <= dest_d;
      rw_q    <= rw_d;
      mr_q    <= mr_d;
      mw_q    <= mw_d;
      br_q    <= br_d;
      valid_q <= valid_d;
      ill_q   <= ill_d;
    end
  end

  assign id_ex_inst      = inst_q;
  assign id_ex_pc        = pc_q;
  assign id_ex_rs_data   = rs_q;
  assign id_ex_rt_data   = rt_q;
  assign id_ex_imm       = imm_q;
  assign id_ex_dest      = dest_q;
  assign id_ex_reg_write = rw_q;
  assign id_ex_mem_read  = mr_q;
  assign id_ex_mem_write = mw_q;
  assign id_ex_branch    = br_q;
  assign id_ex_valid     = valid_q;
  assign id_ex_illegal   = ill_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, reset/stall sequence, and
// randomized traffic checked against a mnemonic-level reference model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_id_inst, if_id_pc, rs_data, rt_data;
  logic        if_id_valid, flush;
  logic [31:0] id_ex_inst, id_ex_pc, id_ex_rs_data, id_ex_rt_data, id_ex_imm;
  logic [4:0]  id_ex_dest;
  logic        id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_branch;
  logic        id_ex_valid, id_ex_illegal, stall;

  int errors = 0;
  int checks = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .if_id_inst(if_id_inst), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid),
    .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
    .id_ex_inst(id_ex_inst), .id_ex_pc(id_ex_pc),
    .id_ex_rs_data(id_ex_rs_data), .id_ex_rt_data(id_ex_rt_data),
    .id_ex_imm(id_ex_imm), .id_ex_dest(id_ex_dest),
    .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_read(id_ex_mem_read),
    .id_ex_mem_write(id_ex_mem_write), .id_ex_branch(id_ex_branch),
    .id_ex_valid(id_ex_valid), .id_ex_illegal(id_ex_illegal), .stall(stall)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic        valid;
    logic [31:0] inst, pc, rs, rt, imm;
    logic [4:0]  dest;
    logic        rw, mr, mw, br, ill;
  } mstate_t;

  typedef struct {
    logic [31:0] inst;
    logic        v, fl, st;
    logic        ev;
    logic [4:0]  ed;
    logic [31:0] eimm;
    logic        rw, mr, mw, br, ill;
  } vec_t;

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'b00000, fn};
  endfunction

  function automatic vec_t row(logic [31:0] inst, logic v, logic fl, logic st, logic ev,
                               logic [4:0] ed, logic [31:0] eimm,
                               logic rw, logic mr, logic mw, logic br, logic ill);
    vec_t r;
    r.inst = inst; r.v = v; r.fl = fl; r.st = st; r.ev = ev; r.ed = ed; r.eimm = eimm;
    r.rw = rw; r.mr = mr; r.mw = mw; r.br = br; r.ill = ill;
    return r;
  endfunction

  function automatic string mnem(logic [31:0] inst);
    logic [5:0] op, fn;
    op = inst[31:26];
    fn = inst[5:0];
    case (op)
      6'd0:  return (fn == 6'd2) ? "SLL" : (fn == 6'd4) ? "XNOR" : (fn == 6'd5) ? "NAND" : "";
      6'd1:  return "ORI";
      6'd6:  return "SUBI";
      6'd7:  return "ADDUI";
      6'd8:  return "LH";
      6'd9:  return "SB";
      6'd11: return "BNE";
      default: return "";
    endcase
  endfunction

  task automatic model_step(input mstate_t cur, input logic [31:0] inst, input logic [31:0] pc,
                            input logic v, input logic [31:0] rsd, input logic [31:0] rtd,
                            input logic fl, output mstate_t nxt, output logic st);
    string m;
    bit legal, rtype, reads_rt;
    logic [4:0] rs, rt;
    m        = mnem(inst);
    legal    = (m != "");
    rtype    = (m == "SLL") || (m == "XNOR") || (m == "NAND");
    reads_rt = rtype || (m == "SB") || (m == "BNE");
    rs       = inst[25:21];
    rt       = inst[20:16];
    st = v && !fl && cur.valid && cur.mr && (cur.dest != 0) &&
         ((legal && cur.dest == rs) || (reads_rt && cur.dest == rt));
    nxt = '0;
    nxt.ill = v && !fl && !st && !legal;
    if (v && !fl && !st && legal) begin
      nxt.valid = 1'b1;
      nxt.inst  = inst;
      nxt.pc    = pc;
      nxt.rs    = rsd;
      nxt.rt    = rtd;
      if (rtype) nxt.dest = inst[15:11];
      else if (m == "SB" || m == "BNE") nxt.dest = 5'd0;
      else nxt.dest = rt;
      if (rtype) nxt.imm = 32'd0;
      else if (m == "ORI" || m == "ADDUI") nxt.imm = 32'(inst[15:0]);
      else nxt.imm = 32'($signed(inst[15:0]));
      nxt.rw = (nxt.dest != 0);
      nxt.mr = (m == "LH");
      nxt.mw = (m == "SB");
      nxt.br = (m == "BNE");
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_state(string tag, mstate_t e);
    chk({tag, " valid"},    32'(id_ex_valid),     32'(e.valid));
    chk({tag, " inst"},     id_ex_inst,           e.inst);
    chk({tag, " pc"},       id_ex_pc,             e.pc);
    chk({tag, " rs_data"},  id_ex_rs_data,        e.rs);
    chk({tag, " rt_data"},  id_ex_rt_data,        e.rt);
    chk({tag, " imm"},      id_ex_imm,            e.imm);
    chk({tag, " dest"},     32'(id_ex_dest),      32'(e.dest));
    chk({tag, " reg_write"},32'(id_ex_reg_write), 32'(e.rw));
    chk({tag, " mem_read"}, 32'(id_ex_mem_read),  32'(e.mr));
    chk({tag, " mem_write"},32'(id_ex_mem_write), 32'(e.mw));
    chk({tag, " branch"},   32'(id_ex_branch),    32'(e.br));
    chk({tag, " illegal"},  32'(id_ex_illegal),   32'(e.ill));
  endtask

  task automatic drive(logic [31:0] inst, logic [31:0] pc, logic v,
                       logic [31:0] rsd, logic [31:0] rtd, logic fl);
    if_id_inst = inst; if_id_pc = pc; if_id_valid = v;
    rs_data = rsd; rt_data = rtd; flush = fl;
  endtask

  localparam logic [5:0] ORI = 6'd1, SUBI = 6'd6, ADDUI = 6'd7, LH = 6'd8, SB = 6'd9, BNE = 6'd11;

  initial begin
    vec_t    tbl[$];
    mstate_t m, nxt, e;
    logic    est;

    rst = 1'b1;
    drive('0, '0, 1'b0, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    cmp_state("reset", '0);
    chk("reset stall", 32'(stall), 32'd0);
    rst = 1'b0;

    //        inst                                      v  fl st  ev dest imm            rw mr mw br ill
    tbl.push_back(row(enc_i(ADDUI, 5'd1, 5'd3, 16'hFFFF), 1, 0, 0, 1, 5'd3, 32'h0000_FFFF, 1, 0, 0, 0, 0));
    tbl.push_back(row(enc_i(SUBI, 5'd1, 5'd4, 16'hFFFF),  1, 0, 0, 1, 5'd4, 32'hFFFF_FFFF, 1, 0, 0, 0, 0));
    tbl.push_back(row(enc_i(SB, 5'd1, 5'd2, 16'h0004),    1, 0, 0, 1, 5'd0, 32'h0000_0004, 0, 0, 1, 0, 0));
    tbl.push_back(row(enc_i(LH, 5'd1, 5'd5, 16'h0000),    1, 0, 0, 1, 5'd5, 32'h0,         1, 1, 0, 0, 0));
    tbl.push_back(row(enc_r(5'd5, 5'd2, 5'd6, 6'd5),      1, 0, 1, 0, 5'd0, 32'h0,         0, 0, 0, 0, 0));
    tbl.push_back(row(enc_r(5'd5, 5'd2, 5'd6, 6'd5),      1, 0, 0, 1, 5'd6, 32'h0,         1, 0, 0, 0, 0));
    tbl.push_back(row(enc_i(LH, 5'd1, 5'd5, 16'h0000),    1, 0, 0, 1, 5'd5, 32'h0,         1, 1, 0, 0, 0));
    tbl.push_back(row(enc_i(ORI, 5'd2, 5'd5, 16'h8001),   1, 0, 0, 1, 5'd5, 32'h0000_8001, 1, 0, 0, 0, 0));
    tbl.push_back(row(enc_i(LH, 5'd1, 5'd0, 16'h0000),    1, 0, 0, 1, 5'd0, 32'h0,         0, 1, 0, 0, 0));
    tbl.push_back(row(enc_r(5'd0, 5'd0, 5'd8, 6'd2),      1, 0, 0, 1, 5'd8, 32'h0,         1, 0, 0, 0, 0));
    tbl.push_back(row(enc_i(LH, 5'd1, 5'd5, 16'hFFFE),    1, 0, 0, 1, 5'd5, 32'hFFFF_FFFE, 1, 1, 0, 0, 0));
    tbl.push_back(row(enc_i(BNE, 5'd5, 5'd2, 16'h0010),   1, 1, 0, 0, 5'd0, 32'h0,         0, 0, 0, 0, 0));
    tbl.push_back(row(32'hFC00_0000,                      1, 0, 0, 0, 5'd0, 32'h0,         0, 0, 0, 0, 1));
    tbl.push_back(row(enc_r(5'd1, 5'd2, 5'd3, 6'h3F),     1, 0, 0, 0, 5'd0, 32'h0,         0, 0, 0, 0, 1));
    tbl.push_back(row(32'hFC00_0000,                      0, 0, 0, 0, 5'd0, 32'h0,         0, 0, 0, 0, 0));
    tbl.push_back(row(enc_i(BNE, 5'd1, 5'd2, 16'h8000),   1, 0, 0, 1, 5'd0, 32'hFFFF_8000, 0, 0, 0, 1, 0));
    tbl.push_back(row(enc_r(5'd1, 5'd2, 5'd0, 6'd4),      1, 0, 0, 1, 5'd0, 32'h0,         0, 0, 0, 0, 0));
    tbl.push_back(row(enc_i(LH, 5'd1, 5'd9, 16'h0000),    1, 0, 0, 1, 5'd9, 32'h0,         1, 1, 0, 0, 0));
    tbl.push_back(row(enc_i(LH, 5'd9, 5'd10, 16'h0000),   1, 0, 1, 0, 5'd0, 32'h0,         0, 0, 0, 0, 0));
    tbl.push_back(row(enc_i(LH, 5'd9, 5'd10, 16'h0000),   1, 0, 0, 1, 5'd10, 32'h0,        1, 1, 0, 0, 0));
    tbl.push_back(row(enc_i(SB, 5'd1, 5'd10, 16'h0000),   1, 0, 1, 0, 5'd0, 32'h0,         0, 0, 0, 0, 0));
    tbl.push_back(row(enc_i(SB, 5'd1, 5'd10, 16'h0000),   1, 0, 0, 1, 5'd0, 32'h0,         0, 0, 1, 0, 0));
    tbl.push_back(row(enc_i(ADDUI, 5'd1, 5'd3, 16'h0001), 0, 0, 0, 0, 5'd0, 32'h0,         0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      logic [31:0] pc, rsd, rtd;
      pc = $urandom; rsd = $urandom; rtd = $urandom;
      drive(tbl[i].inst, pc, tbl[i].v, rsd, rtd, tbl[i].fl);
      #1;
      chk($sformatf("row%0d stall", i), 32'(stall), 32'(tbl[i].st));
      @(posedge clk);
      #1;
      e = '0;
      e.ill = tbl[i].ill;
      if (tbl[i].ev) begin
        e.valid = 1'b1; e.inst = tbl[i].inst; e.pc = pc; e.rs = rsd; e.rt = rtd;
        e.imm = tbl[i].eimm; e.dest = tbl[i].ed;
        e.rw = tbl[i].rw; e.mr = tbl[i].mr; e.mw = tbl[i].mw; e.br = tbl[i].br;
      end
      cmp_state($sformatf("row%0d", i), e);
    end

    // Asynchronous reset mid-cycle while a load-use stall is pending.
    drive(enc_i(LH, 5'd1, 5'd5, 16'h0), 32'h100, 1'b1, 32'h11, 32'h22, 1'b0);
    @(posedge clk);
    #1;
    chk("pre-rst valid", 32'(id_ex_valid), 32'd1);
    drive(enc_r(5'd5, 5'd2, 5'd6, 6'd5), 32'h104, 1'b1, 32'hA5A5_0001, 32'h5A5A_0002, 1'b0);
    #1;
    chk("pre-rst stall", 32'(stall), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    cmp_state("async rst", '0);
    chk("async rst stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("post-rst stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    e = '0;
    e.valid = 1'b1; e.inst = enc_r(5'd5, 5'd2, 5'd6, 6'd5); e.pc = 32'h104;
    e.rs = 32'hA5A5_0001; e.rt = 32'h5A5A_0002; e.dest = 5'd6; e.rw = 1'b1;
    cmp_state("post-rst", e);

    // Randomized traffic against the reference model, from a fresh reset.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    m = '0;
    for (int c = 0; c < 500; c++) begin
      logic [31:0] ins, pc, rsd, rtd;
      logic [5:0]  op, fn;
      logic        v, fl;
      case ($urandom_range(0, 11))
        0, 1:    op = 6'd8;
        2:       op = 6'd1;
        3:       op = 6'd6;
        4:       op = 6'd7;
        5:       op = 6'd9;
        6:       op = 6'd11;
        7:       op = 6'h3F;
        default: op = 6'd0;
      endcase
      case ($urandom_range(0, 6))
        0, 1:    fn = 6'd2;
        2, 3:    fn = 6'd4;
        4, 5:    fn = 6'd5;
        default: fn = 6'h3F;
      endcase
      ins = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 5'($urandom), fn};
      ins[15:6] = (op == 6'd0) ? ins[15:6] : 10'($urandom);
      pc  = $urandom; rsd = $urandom; rtd = $urandom;
      v   = ($urandom_range(0, 9) != 0);
      fl  = ($urandom_range(0, 7) == 0);
      drive(ins, pc, v, rsd, rtd, fl);
      #1;
      model_step(m, ins, pc, v, rsd, rtd, fl, nxt, est);
      chk("rnd stall", 32'(stall), 32'(est));
      @(posedge clk);
      #1;
      m = nxt;
      cmp_state("rnd", m);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage of the 32-bit MIPS-style core. It decodes the instruction held in the IF/ID register, forms the extended immediate, destination register and control bits, and registers them into the ID/EX register. That register feeds the ALU controller and the ALU operand muxes. It also detects load-use hazards and stalls IF/ID, and squashes its output on a branch flush from EX.

## Interface
- No parameters. Widths are fixed: 32-bit datapath, 5-bit register indices.
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- if_id_inst  in  32  instruction in the ID stage
- if_id_pc  in  32  PC+4 of that instruction
- if_id_valid  in  1  ID instruction is real (not a bubble)
- rs_data  in  32  register-file read of inst[25:21]
- rt_data  in  32  register-file read of inst[20:16]
- flush  in  1  branch taken in EX; squash the ID instruction
- id_ex_inst  out  32  registered instruction (ALU controller input)
- id_ex_pc  out  32  registered PC+4
- id_ex_rs_data, id_ex_rt_data  out  32 each  registered operands
- id_ex_imm  out  32  registered extended immediate
- id_ex_dest  out  5  registered destination register index
- id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_branch  out  1 each  registered control
- id_ex_valid  out  1  ID/EX holds a real instruction
- id_ex_illegal  out  1  one-cycle flag: the instruction just retired from ID did not decode
- stall  out  1  combinational; holds PC and IF/ID this cycle

## Operation
- **Opcode map (inst[31:26]).**
  - 000000 R-type; funct inst[5:0] is 000010 SLL, 000100 XNOR or 000101 NAND.
  - 000001 ORI, 000110 SUBI, 000111 ADDUI, 001000 LH, 001001 SB, 001011 BNE.
- **Immediate.** ORI and ADDUI zero-extend inst[15:0]. SUBI, LH, SB and BNE sign-extend inst[15:0]. R-type gives 0.
- **Destination.**
  - R-type: inst[15:11].
  - ORI, SUBI, ADDUI, LH: inst[20:16].
  - SB, BNE: 0, with reg_write=0.
  - Whenever the destination is 0, reg_write is forced to 0.
- **Control.** mem_read=1 only for LH. mem_write=1 only for SB. branch=1 only for BNE.
- **Source usage.**
  - rs is used by every valid opcode.
  - rt is used by R-type, SB and BNE.
  - An unused source never causes a stall.
- **Load-use hazard.** stall=1 when all of the following hold:
  - id_ex_valid and id_ex_mem_read are set;
  - id_ex_dest is nonzero;
  - id_ex_dest equals a used source of the ID instruction;
  - if_id_valid=1 and flush=0.
- **Bubble.** Load a bubble into ID/EX when flush=1, stall=1, if_id_valid=0, or the instruction is illegal. A bubble sets:
  - id_ex_inst=32'h0000_0000, valid=0 and all control bits 0;
  - dest=0, imm=0, operands 0, pc=0.
- **Illegal instruction.** Unknown opcode, or unknown funct with opcode 000000. It is loaded as a bubble. id_ex_illegal=1 for exactly the following cycle, and only if if_id_valid=1 and flush=0.
- **Normal load.** Otherwise, every registered field takes its decoded value and id_ex_valid=1.
- **Priority.** rst > flush > stall > illegal > normal load.

## Timing
- **Reset.** All registered outputs go to 0 immediately on rst assertion, independent of clk. This includes id_ex_inst=0, id_ex_valid=0 and id_ex_illegal=0. stall is 0 while rst=1.
- **Latency.** One cycle: ID inputs sampled at edge N appear on the id_ex_* outputs after edge N.
- **Stall.**
  - stall is combinational from the current ID/EX contents and if_id_inst.
  - Upstream holds IF/ID and PC in the same cycle; this block loads a bubble at that edge.
  - On the next cycle the LH has left ID/EX, so stall drops. The stall is exactly one cycle per load-use pair.
- **Flush.**
  - The bubble is loaded at the edge where flush=1.
  - flush with a hazard present: flush wins and stall=0.
  - Flush for consecutive cycles: a bubble each cycle.
- **Reset mid-stall.** Deasserting rst restarts from an empty ID/EX register. No stall is pending.
- **Back-to-back loads.** LH followed by an LH that uses the first LH's result stalls once. The second LH then loads normally.

## Test plan
- **Reset.** Assert rst asynchronously mid-cycle with ID/EX valid. All outputs are 0 before the next edge, and stall=0.
- **Decode.** Apply ADDUI r3,r1,0xFFFF, then SUBI r4,r1,0xFFFF.
  - ADDUI: id_ex_imm=32'h0000_FFFF, dest=3, reg_write=1.
  - SUBI: id_ex_imm=32'hFFFF_FFFF.
  - SB r2,4(r1): mem_write=1, reg_write=0, dest=0.
- **Load-use.** Apply LH r5,0(r1), then NAND r6,r5,r2.
  - stall=1 for one cycle and id_ex_valid=0 for one cycle.
  - NAND then appears with rs_data as presented in the cycle after the stall.
- **No false stall.** Apply LH r5, then ORI r7,r2,r5-field. No stall, because rt is not used by ORI. Also apply LH r0, then SLL using r0: no stall.
- **Flush priority.** With an LH r5 hazard pending and flush=1: stall=0, a bubble is loaded and id_ex_illegal=0.
- **Illegal.** Apply inst=32'hFC00_0000 and R-type funct 6'b111111 with if_id_valid=1. Each gives id_ex_illegal=1 for one cycle, id_ex_valid=0 and id_ex_inst=0. With if_id_valid=0, the flag stays 0.
